pwm_fade_array: RTL and testbench

- N-channel PWM generator with a shared prescaler and shared period counter.
- Each channel has a shadow target duty register and a linear fade engine; duty changes are applied only at period boundaries, so outputs never glitch.
- Generalises the three-channel RGB PWM wrapper: channel count, resolution and prescale are configurable, and fade and full-on modes are added.
- Sits between a register/control block and the LED pins.

---
 rtl/pwm_pkg.sv | 36 +++
 rtl/pwm_fade_channel.sv | 55 +++++
 rtl/pwm_fade_array.sv | 79 +++++++
 tb/tb_pwm_fade_array.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared helpers for the PWM fade array: duty width,
// saturation of requested duties and the linear fade step.
package pwm_pkg;

    function automatic int duty_w(input int r);
        return r + 1;
    endfunction

    function automatic int unsigned duty_clamp(
        input int unsigned d,
        input int          r
    );
        int unsigned full;
        full = 32'd1 << r;
        return (d > full) ? full : d;
    endfunction

    function automatic int unsigned fade_step(
        input int unsigned cur,
        input int unsigned tgt,
        input int unsigned step
    );
        int unsigned gap;
        if (step == 0) return tgt;
        if (cur < tgt) begin
            gap = tgt - cur;
            return cur + ((step < gap) ? step : gap);
        end
        if (cur > tgt) begin
            gap = cur - tgt;
            return cur - ((step < gap) ? step : gap);
        end
        return cur;
    endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// One PWM lane: shadow target, fading current duty and
// the registered comparator against the shared period count.
module pwm_fade_channel
    import pwm_pkg::*;
#(
    parameter int R = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         pend_i,
    input  logic         load_i,
    input  logic [R:0]   duty_i,
    input  logic [R-1:0] step_i,
    input  logic [R-1:0] cnt_i,
    output logic         busy_o,
    output logic         pwm_o
);

    localparam int DW = duty_w(R);

    logic [DW-1:0] tgt_q;
    logic [DW-1:0] cur_q;
    logic [DW-1:0] tgt_d;
    logic [DW-1:0] cur_d;

    // Next duty state; the fade reads the old target so a load
    // coinciding with a period end only counts from the next one.
    always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        if (load_i) begin
            tgt_d = DW'(duty_clamp(32'(duty_i), R));
        end
        if (pend_i) begin
            cur_d = DW'(fade_step(32'(cur_q), 32'(tgt_q), 32'(step_i)));
        end
    end

    assign busy_o = (cur_d != tgt_d);

    // Duty registers and glitch-free registered output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgt_q <= '0;
            cur_q <= '0;
            pwm_o <= 1'b0;
        end else begin
            tgt_q <= tgt_d;
            cur_q <= cur_d;
            pwm_o <= en_i && ({1'b0, cnt_i} < cur_q);
        end
    end

endmodule

// File: rtl/pwm_fade_array.sv
// N-channel PWM with shared prescaler and period counter;
// per-channel fade engines update only at period boundaries.
module pwm_fade_array
    import pwm_pkg::*;
#(
    parameter int CH         = 3,
    parameter int R          = 8,
    parameter int TIMER_BITS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [TIMER_BITS-1:0] prescale_i,
    input  logic [CH*(R+1)-1:0]   duty_i,
    input  logic [R-1:0]          step_i,
    input  logic                  load_i,
    output logic                  busy_o,
    output logic                  period_o,
    output logic [CH-1:0]         pwm_o
);

    logic [TIMER_BITS-1:0] pre_cnt;
    logic [R-1:0]          cnt;
    logic                  tick;
    logic                  pend;
    logic [CH-1:0]         busy_vec;

    assign tick = en_i && (pre_cnt == prescale_i);
    assign pend = tick && (cnt == '1);

    // Prescaler; disabling parks it at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Period counter, wraps naturally at 2^R.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered period pulse and aggregate busy flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_o <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            period_o <= pend;
            busy_o   <= |busy_vec;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        pwm_fade_channel #(
            .R(R)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (en_i),
            .pend_i (pend),
            .load_i (load_i),
            .duty_i (duty_i[k*(R+1) +: R+1]),
            .step_i (step_i),
            .cnt_i  (cnt),
            .busy_o (busy_vec[k]),
            .pwm_o  (pwm_o[k])
        );
    end

endmodule

// File: tb/tb_pwm_fade_array.sv
// Directed bench for pwm_fade_array: duty, prescale, fades,
// clamp, enable gating and reset abort.
module tb_pwm_fade_array;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [7:0]  prescale_i;
    logic [26:0] duty_i;
    logic [7:0]  step_i;
    logic        load_i;
    logic        busy_o;
    logic        period_o;
    logic [2:0]  pwm_o;

    int n_pass  = 0;
    int n_total = 0;

    pwm_fade_array #(
        .CH(3),
        .R(8),
        .TIMER_BITS(8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .prescale_i (prescale_i),
        .duty_i     (duty_i),
        .step_i     (step_i),
        .load_i     (load_i),
        .busy_o     (busy_o),
        .period_o   (period_o),
        .pwm_o      (pwm_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input logic [8:0] a, input logic [8:0] b,
                            input logic [8:0] c);
        duty_i = {c, b, a};
    endtask

    task automatic pulse_load();
        load_i = 1'b1;
        cyc();
        load_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Runs until the sample that shows period_o, counting high samples.
    task automatic measure(output int n, output int c0, output int c1,
                           output int c2);
        n = 0; c0 = 0; c1 = 0; c2 = 0;
        do begin
            cyc();
            n++;
            c0 += int'(pwm_o[0]);
            c1 += int'(pwm_o[1]);
            c2 += int'(pwm_o[2]);
        end while (!period_o && n < 3000);
    endtask

    task automatic wait_period(output int n);
        int a, b, c;
        measure(n, a, b, c);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; prescale_i = 8'd0;
        duty_i = '0; step_i = 8'd0; load_i = 1'b0;
        cyc();
        cyc();
        n_total++;
        if (pwm_o !== 3'b000) $display("FAIL reset_pwm got %b want 000", pwm_o);
        else n_pass++;
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o);
        else n_pass++;
        n_total++;
        if (period_o !== 1'b0) $display("FAIL reset_period got %b want 0", period_o);
        else n_pass++;
        rst_i = 1'b0;
    endtask

    task automatic test_static_duty();
        int n, c0, c1, c2;
        en_i = 1'b1; prescale_i = 8'd0; step_i = 8'd0;
        set_duty(9'd64, 9'd128, 9'd256);
        cyc();
        pulse_load();
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL t1_busy_rise got %b want 1", busy_o);
        else n_pass++;
        wait_period(n);
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL t1_busy_fall got %b want 0", busy_o);
        else n_pass++;
        measure(n, c0, c1, c2);
        n_total++;
        if (n !== 256) $display("FAIL t1_period got %0d want 256", n);
        else n_pass++;
        n_total++;
        if (c0 !== 64) $display("FAIL t1_ch0 got %0d want 64", c0);
        else n_pass++;
        n_total++;
        if (c1 !== 128) $display("FAIL t1_ch1 got %0d want 128", c1);
        else n_pass++;
        n_total++;
        if (c2 !== 256) $display("FAIL t1_ch2 got %0d want 256", c2);
        else n_pass++;
    endtask

    task automatic test_prescale();
        int n, c0, c1, c2;
        prescale_i = 8'd3;
        set_duty(9'd10, 9'd0, 9'd0);
        pulse_load();
        wait_period(n);
        wait_period(n);
        measure(n, c0, c1, c2);
        n_total++;
        if (n !== 1024) $display("FAIL t2_period got %0d want 1024", n);
        else n_pass++;
        n_total++;
        if (c0 !== 40) $display("FAIL t2_ch0 got %0d want 40", c0);
        else n_pass++;
        n_total++;
        if (c1 !== 0) $display("FAIL t2_ch1 got %0d want 0", c1);
        else n_pass++;
    endtask

    task automatic test_fade_up();
        int n, c0, c1, c2;
        int exp_c;
        do_reset();
        prescale_i = 8'd0; step_i = 8'd16;
        set_duty(9'd100, 9'd0, 9'd0);
        pulse_load();
        wait_period(n);
        for (int i = 0; i < 7; i++) begin
            exp_c = (16 * (i + 1) < 100) ? 16 * (i + 1) : 100;
            n_total++;
            if (busy_o !== (i < 6))
                $display("FAIL t3_busy_%0d got %b want %b", i, busy_o, (i < 6));
            else n_pass++;
            measure(n, c0, c1, c2);
            n_total++;
            if (c0 !== exp_c)
                $display("FAIL t3_cur_%0d got %0d want %0d", i, c0, exp_c);
            else n_pass++;
        end
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL t3_busy_end got %b want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_fade_down();
        int n, c0, c1, c2;
        int exp_seq[4] = '{20, 36, 52, 60};
        do_reset();
        prescale_i = 8'd0; step_i = 8'd16;
        set_duty(9'd100, 9'd0, 9'd0);
        pulse_load();
        wait_period(n);
        measure(n, c0, c1, c2);
        measure(n, c0, c1, c2);
        set_duty(9'd20, 9'd0, 9'd0);
        pulse_load();
        measure(n, c0, c1, c2);
        measure(n, c0, c1, c2);
        n_total++;
        if (c0 !== 32) $display("FAIL t4_down1 got %0d want 32", c0);
        else n_pass++;
        measure(n, c0, c1, c2);
        n_total++;
        if (c0 !== 20) $display("FAIL t4_down2 got %0d want 20", c0);
        else n_pass++;
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL t4_busy_idle got %b want 0", busy_o);
        else n_pass++;
        for (int j = 0; j < 255; j++) cyc();
        set_duty(9'd60, 9'd0, 9'd0);
        pulse_load();
        n_total++;
        if (period_o !== 1'b1) $display("FAIL t4_pend_align got %b want 1", period_o);
        else n_pass++;
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL t4_pend_busy got %b want 1", busy_o);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            measure(n, c0, c1, c2);
            n_total++;
            if (c0 !== exp_seq[i])
                $display("FAIL t4_onpend_%0d got %0d want %0d", i, c0, exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_clamp_enable();
        int n, c0, c1, c2;
        int bad;
        step_i = 8'd0;
        set_duty(9'd511, 9'd0, 9'd300);
        pulse_load();
        wait_period(n);
        wait_period(n);
        measure(n, c0, c1, c2);
        n_total++;
        if (c0 !== 256) $display("FAIL t5_clamp0 got %0d want 256", c0);
        else n_pass++;
        n_total++;
        if (c1 !== 0) $display("FAIL t5_zero got %0d want 0", c1);
        else n_pass++;
        n_total++;
        if (c2 !== 256) $display("FAIL t5_clamp2 got %0d want 256", c2);
        else n_pass++;
        for (int j = 0; j < 100; j++) cyc();
        en_i = 1'b0;
        bad = 0;
        for (int j = 0; j < 500; j++) begin
            cyc();
            if (pwm_o !== 3'b000 || period_o !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL t5_disabled got %0d active samples want 0", bad);
        else n_pass++;
        en_i = 1'b1;
        measure(n, c0, c1, c2);
        n_total++;
        if (n !== 256) $display("FAIL t5_restart got %0d want 256", n);
        else n_pass++;
        n_total++;
        if (c0 !== 256) $display("FAIL t5_frozen got %0d want 256", c0);
        else n_pass++;
    endtask

    task automatic test_reset_midfade();
        int n;
        step_i = 8'd16;
        set_duty(9'd0, 9'd0, 9'd0);
        pulse_load();
        wait_period(n);
        for (int j = 0; j < 50; j++) cyc();
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL t6_pre_busy got %b want 1", busy_o);
        else n_pass++;
        rst_i = 1'b1;
        prescale_i = 8'd1;
        cyc();
        n_total++;
        if ({pwm_o, busy_o, period_o} !== 5'b0)
            $display("FAIL t6_abort got %b want 00000", {pwm_o, busy_o, period_o});
        else n_pass++;
        rst_i = 1'b0;
        wait_period(n);
        n_total++;
        if (n !== 512) $display("FAIL t6_first_period got %0d want 512", n);
        else n_pass++;
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL t6_busy_after got %b want 0", busy_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_static_duty();
        test_prescale();
        test_fade_up();
        test_fade_down();
        test_clamp_enable();
        test_reset_midfade();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
